// File: rtl/param_seq_alu.sv
// Multi-cycle unsigned ALU: operands arrive serially (A then B), MUL is a
// W-step shift-add; done pulses for one cycle while result/overflow update.
module param_seq_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  opcode_valid,
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  busy,
    output logic [2:0]            dbg_state
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [2:0] {IDLE, LOAD_B, EXEC, MUL, DONE} state_t;

    state_t          state;
    logic [2:0]      op;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    alu_res;
    logic            alu_ov;
    logic [W:0]      sum;
    logic [2*W-1:0]  shl_wide;
    logic [2*W-1:0]  mul_next;

    assign dbg_state = state;

    // Single-cycle operations; opcode 111 falls to the default error result.
    always_comb begin
        alu_res  = '0;
        alu_ov   = 1'b0;
        sum      = '0;
        shl_wide = '0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[W-1:0];
                alu_ov  = sum[W];
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_ov  = (a < b);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                // Shifts of W or more lose every bit of A.
                if ({1'b0, b} >= (W + 1)'(W)) begin
                    alu_ov = |a;
                end else begin
                    shl_wide = {{W{1'b0}}, a} << b;
                    alu_res  = shl_wide[W-1:0];
                    alu_ov   = |shl_wide[2*W-1:W];
                end
            end
            OP_MUL: alu_res = '0;
            default: alu_ov = 1'b1;
        endcase
    end

    // MSB-first shift-add: B is consumed from its top bit, one bit per step.
    assign mul_next = {prod[2*W-2:0], 1'b0} + (b[W-1] ? {{W{1'b0}}, a} : '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            op       <= '0;
            a        <= '0;
            b        <= '0;
            prod     <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (opcode_valid) begin
                        op    <= opcode;
                        a     <= data;
                        busy  <= 1'b1;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    b     <= data;
                    state <= EXEC;
                end
                EXEC: begin
                    if (op == OP_MUL) begin
                        prod  <= '0;
                        cnt   <= CW'(W);
                        state <= MUL;
                    end else begin
                        result   <= alu_res;
                        overflow <= alu_ov;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    b    <= {b[W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result   <= mul_next[W-1:0];
                        overflow <= |mul_next[2*W-1:W];
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_seq_alu.sv
// Directed and randomized checks of param_seq_alu (DATA_WIDTH=8) against an
// arithmetic reference model.
module tb_param_seq_alu;
    localparam int W = 8;
    localparam longint MODV = longint'(1) << W;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         opcode_valid = 1'b0;
    logic [2:0]   opcode = '0;
    logic [W-1:0] data = '0;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         busy;
    logic [2:0]   dbg_state;

    int tests = 0;
    int failed = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    param_seq_alu #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .done         (done),
        .result       (result),
        .overflow     (overflow),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Reference: {overflow, result} from plain unsigned arithmetic.
    function automatic logic [W:0] model(input int op, input longint a, input longint b);
        longint full;
        logic [W-1:0] r;
        logic         ov;
        r = '0;
        ov = 1'b0;
        case (op)
            0: begin full = a + b; r = W'(full % MODV); ov = (full >= MODV); end
            1: begin r = W'((a - b + MODV) % MODV); ov = (a < b); end
            2: r = W'(a & b);
            3: r = W'(a | b);
            4: r = W'(a ^ b);
            5: begin
                if (b >= W) begin r = '0; ov = (a != 0); end
                else begin full = a * (longint'(1) << b); r = W'(full % MODV); ov = (full >= MODV); end
            end
            6: begin full = a * b; r = W'(full % MODV); ov = (full >= MODV); end
            default: begin r = '0; ov = 1'b1; end
        endcase
        return {ov, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold keeps opcode_valid high throughout.
    task automatic run_op(input int op, input int av, input int bv, input bit hold, input string tag);
        logic [W:0]   exp;
        logic [W-1:0] prev_res;
        int           k;
        int           want;
        exp = model(op, av, bv);
        prev_res = result;
        opcode_valid = 1'b1;
        opcode = 3'(op);
        data = W'(av);
        tick();
        check({tag, "_busy_e0"}, busy, 1);
        opcode_valid = hold;
        opcode = 3'($urandom_range(0, 7));
        data = W'(bv);
        tick();
        check({tag, "_hold_res"}, result, prev_res);
        data = W'($urandom);
        want = (op == 6) ? 1 + W : 1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < 60);
        check({tag, "_latency"}, k, want);
        exp_q.push_back(exp[W-1:0]);
        check({tag, "_result"}, result, exp_q.pop_front());
        check({tag, "_overflow"}, overflow, exp[W]);
        check({tag, "_busy_done"}, busy, 1);
        tick();
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int ops;
        int av;
        int bv;
        int pulses;

        // Reset wins over a simultaneous request.
        reset_n = 1'b0;
        opcode_valid = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        opcode_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        run_op(0, 200, 100, 1'b0, "add");
        run_op(1, 5, 7, 1'b0, "sub");
        run_op(4, 8'hF0, 8'hFF, 1'b0, "xor");
        run_op(6, 20, 13, 1'b0, "mul_a");
        run_op(6, 15, 17, 1'b0, "mul_b");
        run_op(5, 8'h81, 1, 1'b0, "shl_1");
        run_op(5, 0, 9, 1'b0, "shl_9");
        run_op(5, 8'h3, 200, 1'b0, "shl_big");
        run_op(7, 33, 44, 1'b0, "illegal");
        run_op(2, 8'hA5, 8'h3C, 1'b0, "and");
        run_op(3, 8'hA5, 8'h3C, 1'b0, "or");

        // Request held high: exactly one completion, next accept right after DONE.
        run_op(0, 1, 2, 1'b1, "hold_a");
        run_op(1, 9, 4, 1'b0, "hold_b");

        // Reset during MUL step 4 aborts with no done pulse.
        opcode_valid = 1'b1;
        opcode = 3'd6;
        data = 8'd99;
        tick();
        opcode_valid = 1'b0;
        data = 8'd77;
        tick();
        repeat (4) tick();
        reset_n = 1'b0;
        opcode_valid = 1'b1;
        tick();
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_overflow", overflow, 0);
        reset_n = 1'b1;
        opcode_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        run_op(6, 255, 255, 1'b0, "mul_max");

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            ops = $urandom_range(0, 7);
            av = $urandom_range(0, 255);
            bv = (ops == 5 && $urandom_range(0, 3) != 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            run_op(ops, av, bv, 1'($urandom_range(0, 1)), "rand");
            opcode_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
